// File: rtl/uart_rx_cmd_decoder_pkg.sv
// Shared constants for the UART host-command decoder: frame header default,
// FSM state encodings, error codes and the host register map entries that
// software and the bench both rely on.
package uart_rx_cmd_decoder_pkg;

  localparam logic [7:0] FRAME_HEAD_DEF  = 8'hAA;
  localparam int         TIMEOUT_CYC_DEF = 200000;

  // Host register addresses reachable through the decoder
  localparam logic [7:0] ADDR_UART_EN_TX = 8'd4;
  localparam logic [7:0] ADDR_BAUD_SET   = 8'd5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_DATA_H = 3'd2,
    ST_DATA_L = 3'd3,
    ST_CHK    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_CHK     = 2'b01,
    ERR_TIMEOUT = 2'b10
  } err_code_e;

  // 8-bit wrap-around accumulate used for the frame checksum
  function automatic logic [7:0] chk_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/uart_rx_cmd_decoder_if.sv
// Byte-receiver input and host-bus write output of the command decoder.
// The slave modport is the decoder's view; master is the byte source /
// register-bank side that drives bytes in and observes the writes.
interface uart_rx_cmd_decoder_if;
  import uart_rx_cmd_decoder_pkg::*;

  logic        Rx_Done;
  logic [7:0]  Rx_Data;
  logic        m_wr;
  logic [7:0]  m_addr;
  logic [15:0] m_wrdata;
  logic        Frame_Err;
  err_code_e   Err_Code;
  logic        Busy;

  modport slave (
    input  Rx_Done, Rx_Data,
    output m_wr, m_addr, m_wrdata, Frame_Err, Err_Code, Busy
  );

  modport master (
    output Rx_Done, Rx_Data,
    input  m_wr, m_addr, m_wrdata, Frame_Err, Err_Code, Busy
  );

endinterface

// File: rtl/uart_rx_cmd_decoder_timeout.sv
// Inter-byte watchdog: counts idle cycles while a frame is open and flags
// the cycle in which the count hits its terminal value with no byte arriving.
module uart_rx_timeout #(
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // A byte always wins over expiry, so clear_i masks the terminal count
  assign expired_o = enable_i && !clear_i && (cnt_q == CNT_LAST);

  // Restart on each byte, on expiry and whenever no frame is open
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear_i || !enable_i || expired_o) begin
      cnt_d = '0;
    end
  end

  // Counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_cmd_decoder.sv
// Parses 5-byte frames (HEAD, ADDR, DATA_H, DATA_L, CHK) from the UART byte
// receiver and issues one host-bus register write per good frame. Bad
// checksums and stalled frames are discarded with a Frame_Err pulse.
module uart_rx_cmd_decoder
  import uart_rx_cmd_decoder_pkg::*;
#(
  parameter logic [7:0] FRAME_HEAD  = FRAME_HEAD_DEF,
  parameter int         TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input logic                   Clk,
  input logic                   Rst,
  uart_rx_cmd_decoder_if.slave  bus
);

  state_e      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  dh_q, dh_d;
  logic [7:0]  dl_q, dl_d;
  logic [7:0]  sum_q, sum_d;

  logic        wr_q, wr_d;
  logic [7:0]  maddr_q, maddr_d;
  logic [15:0] mdata_q, mdata_d;
  logic        ferr_q, ferr_d;
  err_code_e   ecode_q, ecode_d;
  logic        busy_q;

  logic        expired;

  uart_rx_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk_i     (Clk),
    .rst_i     (Rst),
    .clear_i   (bus.Rx_Done),
    .enable_i  (state_q != ST_IDLE),
    .expired_o (expired)
  );

  // Frame FSM: advance on each received byte, abandon the frame on timeout
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    dh_d    = dh_q;
    dl_d    = dl_q;
    sum_d   = sum_q;
    wr_d    = 1'b0;
    maddr_d = maddr_q;
    mdata_d = mdata_q;
    ferr_d  = 1'b0;
    ecode_d = ecode_q;

    if (bus.Rx_Done) begin
      case (state_q)
        ST_IDLE: begin
          // Stray bytes between frames are dropped without complaint
          if (bus.Rx_Data == FRAME_HEAD) begin
            state_d = ST_ADDR;
          end
        end
        ST_ADDR: begin
          addr_d  = bus.Rx_Data;
          sum_d   = bus.Rx_Data;
          state_d = ST_DATA_H;
        end
        ST_DATA_H: begin
          dh_d    = bus.Rx_Data;
          sum_d   = chk_add(sum_q, bus.Rx_Data);
          state_d = ST_DATA_L;
        end
        ST_DATA_L: begin
          dl_d    = bus.Rx_Data;
          sum_d   = chk_add(sum_q, bus.Rx_Data);
          state_d = ST_CHK;
        end
        ST_CHK: begin
          state_d = ST_IDLE;
          if (bus.Rx_Data == sum_q) begin
            wr_d    = 1'b1;
            maddr_d = addr_q;
            mdata_d = {dh_q, dl_q};
          end else begin
            ferr_d  = 1'b1;
            ecode_d = ERR_CHK;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else if (expired) begin
      state_d = ST_IDLE;
      ferr_d  = 1'b1;
      ecode_d = ERR_TIMEOUT;
    end
  end

  // State, shadow and output registers; reset clears a partial frame too
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      dh_q    <= '0;
      dl_q    <= '0;
      sum_q   <= '0;
      wr_q    <= 1'b0;
      maddr_q <= '0;
      mdata_q <= '0;
      ferr_q  <= 1'b0;
      ecode_q <= ERR_NONE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dh_q    <= dh_d;
      dl_q    <= dl_d;
      sum_q   <= sum_d;
      wr_q    <= wr_d;
      maddr_q <= maddr_d;
      mdata_q <= mdata_d;
      ferr_q  <= ferr_d;
      ecode_q <= ecode_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign bus.m_wr      = wr_q;
  assign bus.m_addr    = maddr_q;
  assign bus.m_wrdata  = mdata_q;
  assign bus.Frame_Err = ferr_q;
  assign bus.Err_Code  = ecode_q;
  assign bus.Busy      = busy_q;

endmodule
